// File: rtl/dcache_pkg.sv
// dcache_pkg: shared wordlen encodings and request-queue entry sizing
package dcache_pkg;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} wordlen_e;
  localparam int ENTRY_CTRL_BITS = 4;
  function automatic int entry_bits(input int databits, input int addrbits);
    return databits + addrbits + ENTRY_CTRL_BITS;
  endfunction
endpackage

// File: rtl/dcache_reqqueue_mem.sv
// dcache_reqqueue_mem: queue storage with one write port, async head read and a full view for hazard lookup
module dcache_reqqueue_mem #(
  parameter int EW = 68,
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_waddr,
  input  logic [EW-1:0]            i_wdata,
  input  logic [AW-1:0]            i_raddr,
  output logic [EW-1:0]            o_rdata,
  output logic [DEPTH-1:0][EW-1:0] o_entries
);
  logic [DEPTH-1:0][EW-1:0] r_mem;
  // entries are written only on accepted pushes; contents survive reset
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata   = r_mem[i_raddr];
  assign o_entries = r_mem;
endmodule

// File: rtl/dcache_reqqueue.sv
// dcache_reqqueue: in-order data-cache request FIFO with overflow flag and pending-write address lookup
module dcache_reqqueue
  import dcache_pkg::*;
#(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 32,
  parameter int QUEUECNTBITS = 3,
  parameter int QUEUESIZE = 2**QUEUECNTBITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATABITS-1:0]     queue_in_data,
  input  logic [ADDRBITS-1:0]     queue_in_addr,
  input  logic                    queue_in_rdreq,
  input  logic                    queue_in_wrreq,
  input  logic [1:0]              queue_in_wordlen,
  input  logic                    queue_push,
  input  logic                    queue_pop,
  input  logic                    queue_flush,
  input  logic [ADDRBITS-1:0]     queue_lookup_addr,
  output logic [DATABITS-1:0]     queue_out_data,
  output logic [ADDRBITS-1:0]     queue_out_addr,
  output logic                    queue_out_rdreq,
  output logic                    queue_out_wrreq,
  output logic [1:0]              queue_out_wordlen,
  output logic                    queue_not_empty,
  output logic                    queue_full,
  output logic [QUEUECNTBITS:0]   queue_count,
  output logic                    queue_overflow,
  output logic                    queue_lookup_hit
);
  localparam int CB = QUEUECNTBITS;
  localparam int EW = entry_bits(DATABITS, ADDRBITS);
  localparam int WR_BIT = DATABITS + ADDRBITS + 1;
  logic [CB:0] r_wr, r_rd, w_count;
  logic r_ovf, w_full, w_empty, w_push, w_pop, w_we, w_hit, w_unused;
  logic [EW-1:0] w_head;
  logic [QUEUESIZE-1:0][EW-1:0] w_entries;
  assign w_count = r_wr - r_rd;
  assign w_empty = r_wr == r_rd;
  assign w_full  = (r_wr[CB] != r_rd[CB]) && (r_wr[CB-1:0] == r_rd[CB-1:0]);
  assign w_pop   = queue_pop & ~w_empty;
  assign w_push  = queue_push & (~w_full | w_pop);
  assign w_we    = w_push & ~reset & ~queue_flush;
  dcache_reqqueue_mem #(.EW(EW), .DEPTH(QUEUESIZE), .AW(CB)) u_mem (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (r_wr[CB-1:0]),
    .i_wdata   ({queue_in_wordlen, queue_in_wrreq, queue_in_rdreq, queue_in_addr, queue_in_data}),
    .i_raddr   (r_rd[CB-1:0]),
    .o_rdata   (w_head),
    .o_entries (w_entries)
  );
  // pointer and sticky-overflow update; reset beats flush, flush beats push/pop
  always_ff @(posedge clk)
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else if (queue_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr  <= r_wr + {{CB{1'b0}}, w_push};
      r_rd  <= r_rd + {{CB{1'b0}}, w_pop};
      r_ovf <= r_ovf | (queue_push & w_full & ~queue_pop);
    end
  // a slot is held when its distance from the read pointer is below the count
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < QUEUESIZE; i++)
      w_hit = w_hit | (({1'b0, CB'(CB'(i) - r_rd[CB-1:0])} < w_count) && w_entries[i][WR_BIT] &&
              (w_entries[i][DATABITS+ADDRBITS-1:DATABITS+2] == queue_lookup_addr[ADDRBITS-1:2]));
  end
  assign w_unused = ^{queue_lookup_addr[1:0], w_entries};
  assign {queue_out_wordlen, queue_out_wrreq, queue_out_rdreq, queue_out_addr, queue_out_data} = w_head;
  assign queue_not_empty  = ~w_empty;
  assign queue_full       = w_full;
  assign queue_count      = w_count;
  assign queue_overflow   = r_ovf;
  assign queue_lookup_hit = w_hit;
endmodule

// File: tb/tb_dcache_reqqueue.sv
// tb_dcache_reqqueue: directed checks of ordering, full/empty corners, lookup, flush and reset
module tb_dcache_reqqueue;
  logic clk = 0, reset = 0;
  logic [31:0] d = 0, a = 0, la = 0;
  logic rd = 0, wr = 0, push = 0, pop = 0, flush = 0;
  logic [1:0] wl = 0;
  logic [31:0] o_d, o_a;
  logic o_rd, o_wr, o_ne, o_full, o_ovf, o_hit;
  logic [1:0] o_wl;
  logic [3:0] o_cnt;
  int n_chk = 0, n_err = 0;
  logic [31:0] mq[$];
  logic [31:0] tmp;
  dcache_reqqueue dut (
    .clk(clk), .reset(reset), .queue_in_data(d), .queue_in_addr(a), .queue_in_rdreq(rd),
    .queue_in_wrreq(wr), .queue_in_wordlen(wl), .queue_push(push), .queue_pop(pop),
    .queue_flush(flush), .queue_lookup_addr(la), .queue_out_data(o_d), .queue_out_addr(o_a),
    .queue_out_rdreq(o_rd), .queue_out_wrreq(o_wr), .queue_out_wordlen(o_wl),
    .queue_not_empty(o_ne), .queue_full(o_full), .queue_count(o_cnt),
    .queue_overflow(o_ovf), .queue_lookup_hit(o_hit)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1;
    tick();
    tick();
    reset = 0;
    chk("rst_count", o_cnt, 0);
    chk("rst_ne", o_ne, 0);
    chk("rst_full", o_full, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_hit", o_hit, 0);
    rd = 1; wr = 0; wl = 2; push = 1; la = 32'h100;
    for (int i = 0; i < 8; i++) begin
      d = i; a = 32'h100 + 4 * i;
      tick();
      chk("fill_count", o_cnt, i + 1);
    end
    chk("fill_full", o_full, 1);
    chk("fill_ne", o_ne, 1);
    chk("fill_hit_rdonly", o_hit, 0);
    chk("fill_ovf_clear", o_ovf, 0);
    d = 32'h99; a = 32'h200;
    tick();
    chk("ovf_set", o_ovf, 1);
    chk("ovf_count", o_cnt, 8);
    chk("ovf_head_addr", o_a, 32'h100);
    chk("ovf_head_data", o_d, 0);
    d = 32'hAA; a = 32'h120; pop = 1;
    tick();
    chk("pp_full_count", o_cnt, 8);
    chk("pp_full_flag", o_full, 1);
    chk("pp_head_addr", o_a, 32'h104);
    chk("pp_head_data", o_d, 1);
    push = 0;
    for (int i = 1; i < 9; i++) begin
      chk("drain_addr", o_a, i < 8 ? 32'h100 + 4 * i : 32'h120);
      chk("drain_data", o_d, i < 8 ? i : 32'hAA);
      tick();
    end
    chk("drain_ne", o_ne, 0);
    chk("drain_count", o_cnt, 0);
    tick();
    chk("pop_empty_count", o_cnt, 0);
    chk("pop_empty_ne", o_ne, 0);
    chk("pop_empty_ovf", o_ovf, 1);
    d = 32'h55; a = 32'h300; push = 1; pop = 1;
    tick();
    chk("pp_empty_count", o_cnt, 1);
    chk("pp_empty_data", o_d, 32'h55);
    push = 0;
    tick();
    chk("pp_empty_drained", o_cnt, 0);
    for (int i = 0; i < 20; i++) begin
      d = 32'h500 + i; a = 32'h400 + 4 * i; push = 1;
      pop = mq.size() >= 2;
      if (pop) tmp = mq.pop_front();
      mq.push_back(d);
      tick();
      chk("alt_head", o_d, mq[0]);
      chk("alt_count", o_cnt, mq.size());
    end
    push = 0; pop = 1;
    while (mq.size() > 0) begin
      tmp = mq.pop_front();
      chk("alt_drain", o_d, tmp);
      tick();
    end
    chk("alt_empty", o_ne, 0);
    pop = 0; push = 1; rd = 0; wr = 1; wl = 0; d = 32'h11; a = 32'h2004;
    tick();
    push = 0; la = 32'h2006;
    #1;
    chk("lk_hit_same_word", o_hit, 1);
    chk("lk_head_wl", o_wl, 0);
    chk("lk_head_wr", o_wr, 1);
    la = 32'h2008;
    #1;
    chk("lk_miss_next_word", o_hit, 0);
    push = 1; a = 32'h3000; la = 32'h3000;
    #1;
    chk("lk_same_cycle", o_hit, 0);
    tick();
    chk("lk_next_cycle", o_hit, 1);
    a = 32'h3100;
    tick();
    chk("fl_pre_count", o_cnt, 3);
    flush = 1;
    tick();
    flush = 0; push = 0;
    chk("fl_count", o_cnt, 0);
    chk("fl_ne", o_ne, 0);
    chk("fl_ovf", o_ovf, 1);
    chk("fl_hit", o_hit, 0);
    push = 1; a = 32'h3000;
    for (int i = 0; i < 4; i++) tick();
    chk("rs_pre_count", o_cnt, 4);
    chk("rs_pre_hit", o_hit, 1);
    reset = 1;
    tick();
    reset = 0; push = 0;
    chk("rs_count", o_cnt, 0);
    chk("rs_ne", o_ne, 0);
    chk("rs_full", o_full, 0);
    chk("rs_ovf", o_ovf, 0);
    chk("rs_hit", o_hit, 0);
    push = 1; d = 32'h77; a = 32'h700; wr = 0; rd = 1;
    tick();
    push = 0;
    chk("rs_new_addr", o_a, 32'h700);
    chk("rs_new_data", o_d, 32'h77);
    chk("rs_new_count", o_cnt, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dcache_reqqueue.md
DCACHE_REQQUEUE -- requirements
Module: dcache_reqqueue

Interface
REQ-001 The module SHALL have parameter DATABITS, default 32, data field width.
REQ-002 The module SHALL have parameter ADDRBITS, default 32, address field width.
REQ-003 The module SHALL have parameter QUEUECNTBITS, default 3, log2 of depth.
REQ-004 The module SHALL have parameter QUEUESIZE, default 2**QUEUECNTBITS, entry count.
REQ-005 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- queue_in_data  in  DATABITS  write data.
- queue_in_addr  in  ADDRBITS  byte address.
- queue_in_rdreq  in  1  read request flag.
- queue_in_wrreq  in  1  write request flag.
- queue_in_wordlen  in  2  access size.
- queue_push  in  1  enqueue request.
- queue_pop  in  1  dequeue request.
- queue_flush  in  1  discard all entries.
- queue_lookup_addr  in  ADDRBITS  hazard probe address.
- queue_out_data  out  DATABITS  head data.
- queue_out_addr  out  ADDRBITS  head address.
- queue_out_rdreq  out  1  head read flag.
- queue_out_wrreq  out  1  head write flag.
- queue_out_wordlen  out  2  head size.
- queue_not_empty  out  1  at least one entry held.
- queue_full  out  1  QUEUESIZE entries held.
- queue_count  out  QUEUECNTBITS+1  entries held.
- queue_overflow  out  1  sticky: push rejected.
- queue_lookup_hit  out  1  pending write matches probe.

Function
REQ-006 Storage SHALL be QUEUESIZE entries of {wordlen, wrreq, rdreq, addr, data}, circular, in-order.
REQ-007 Pointers SHALL be QUEUECNTBITS+1 bits; empty = pointers equal; full = lower bits equal and MSBs differ.
REQ-008 A push accepted at edge N SHALL make the entry visible on queue_out_* and queue_not_empty after edge N (one-cycle latency).
REQ-009 queue_out_* SHALL combinationally present the head entry; values are don't-care while queue_not_empty=0.
REQ-010 Push with queue_full=1 and no pop SHALL be dropped, leave state unchanged, and set queue_overflow.
REQ-011 Pop with queue_not_empty=0 SHALL be ignored; pointers unchanged; no flag set.
REQ-012 Simultaneous push and pop when full SHALL both take effect; count stays QUEUESIZE.
REQ-013 Simultaneous push and pop when empty SHALL accept the push only; count becomes 1.
REQ-014 Pointer increment SHALL wrap modulo 2*QUEUESIZE without corrupting order.
REQ-015 queue_flush SHALL override push and pop: pointers to 0, count 0; queue_overflow unchanged.
REQ-016 queue_count SHALL equal write pointer minus read pointer, modulo 2**(QUEUECNTBITS+1).
REQ-017 queue_lookup_hit SHALL be 1 combinationally when any held entry has wrreq=1 and addr[ADDRBITS-1:2] equals queue_lookup_addr[ADDRBITS-1:2]; an entry pushed in the current cycle SHALL NOT count.

Reset
REQ-018 On reset=1 at a clock edge, pointers SHALL clear, queue_count=0, queue_not_empty=0, queue_full=0, queue_overflow=0, queue_lookup_hit=0.
REQ-019 Reset mid-operation SHALL discard all entries and take priority over flush, push and pop; storage contents need not be cleared.
REQ-020 queue_overflow SHALL clear only on reset.

Structure
REQ-021 Package dcache_pkg SHALL hold wordlen encodings (BYTE=0, HALF=1, WORD=2) and the entry-width expression DATABITS+ADDRBITS+4.
REQ-022 Storage SHALL be a sub-module dcache_reqqueue_mem (write port, async read port), with pointer, flag and lookup logic in the top.

Verification
REQ-023 Push 8 entries (addr 0x100+4i, data i) with default parameters -> queue_full=1, count=8; 9th push -> dropped, queue_overflow=1, head still addr 0x100.
REQ-024 Full queue, push+pop same cycle (data 0xAA) -> count 8, head becomes addr 0x104, 0xAA at tail; pop order verified.
REQ-025 Push/pop 20 entries through an alternating pattern -> pointers wrap, output order matches input order exactly.
REQ-026 Push write to 0x2004 (wordlen=0), probe 0x2006 -> lookup_hit=1; probe 0x2008 -> 0; same-cycle push of 0x3000 with probe 0x3000 -> 0, next cycle 1.
REQ-027 Three entries held, assert queue_flush with push -> count 0, not_empty 0 next cycle; overflow unchanged.
REQ-028 Pop on empty, then reset asserted with 4 entries held -> all outputs at reset values, subsequent push appears as head.
